simple_spi_loopback: RTL and testbench

//  Self-contained SPI mode-0 loopback: an internal master serialises bytes over an internal

---
 rtl/simple_spi_loopback.sv | 127 ++++++++++++
 tb/tb_simple_spi_loopback.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/simple_spi_loopback.sv
// SPI mode-0 loopback: an internal master shifts an incrementing byte sequence
// to an internal slave over a divided sclk; the slave publishes each full byte on dout.
module simple_spi_loopback #(
  parameter int         CLK_DIV = 4,
  parameter logic [7:0] TX_SEED = 8'hA5,
  parameter logic [7:0] TX_STEP = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  output logic [7:0] dout
);

  localparam int              DIV_W   = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [DIV_W-1:0] div_q;
  logic             sclk_q;
  logic             tick;
  logic             rise_tick;
  logic             fall_tick;

  state_t           state_q, state_d;
  logic [7:0]       tx_byte_q;
  logic [7:0]       sh_q;
  logic [2:0]       bitcnt_q;
  logic             cs_n;
  logic             mosi;

  logic [6:0]       rx_q;
  logic [2:0]       rx_cnt_q;
  logic [7:0]       dout_q;

  // sclk is only a data signal; everything below advances on clk qualified by the ticks.
  assign tick      = (div_q == DIV_MAX);
  assign rise_tick = tick & ~sclk_q;
  assign fall_tick = tick &  sclk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (tick) begin
      div_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fall_tick) begin
      case (state_q)
        S_IDLE:  if (tx_enable) state_d = S_SEND;
        S_SEND:  if (bitcnt_q == 3'd7) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cs_n = 1'b1;
    mosi = 1'b0;
    if (state_q == S_SEND) begin
      cs_n = 1'b0;
      mosi = sh_q[7];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_byte_q <= TX_SEED;
      sh_q      <= '0;
      bitcnt_q  <= '0;
    end else if (fall_tick) begin
      case (state_q)
        S_IDLE: begin
          if (tx_enable) begin
            sh_q     <= tx_byte_q;
            bitcnt_q <= '0;
          end
        end
        S_SEND: begin
          sh_q     <= {sh_q[6:0], 1'b0};
          bitcnt_q <= bitcnt_q + 1'b1;
        end
        S_DONE:  tx_byte_q <= tx_byte_q + TX_STEP;
        default: ;
      endcase
    end
  end

  // The 8th bit goes straight into dout so the byte lands in the same cycle it completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_q     <= '0;
      rx_cnt_q <= '0;
      dout_q   <= '0;
    end else if (cs_n) begin
      rx_cnt_q <= '0;
    end else if (rise_tick) begin
      rx_q <= {rx_q[5:0], mosi};
      if (rx_cnt_q == 3'd7) begin
        dout_q   <= {rx_q, mosi};
        rx_cnt_q <= '0;
      end else begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_simple_spi_loopback.sv
// Bench for simple_spi_loopback: default instance plus a CLK_DIV=2 / 3C / +05 instance.
module tb_simple_spi_loopback;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       tx_en2;
  logic [7:0] dout;
  logic [7:0] dout2;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    string      name;
    int         budget;
    int         min_gap;
    int         max_gap;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  simple_spi_loopback u_dut (
    .clk       (clk),
    .rst       (rst),
    .tx_enable (tx_en),
    .dout      (dout)
  );

  simple_spi_loopback #(
    .CLK_DIV (2),
    .TX_SEED (8'h3C),
    .TX_STEP (8'h05)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .tx_enable (tx_en2),
    .dout      (dout2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_bit(input string name, input bit act, input bit exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits up to budget clk for the selected dout to change; sampled on negedge.
  task automatic wait_change(input bit sel, input int budget,
                             output logic [7:0] v, output int lat, output bit ok);
    logic [7:0] prev;
    logic [7:0] cur;
    int         i;
    prev = sel ? dout2 : dout;
    ok   = 1'b0;
    lat  = 0;
    v    = prev;
    i    = 0;
    while (!ok && i < budget) begin
      @(negedge clk);
      i++;
      cur = sel ? dout2 : dout;
      if (cur !== prev) begin
        ok  = 1'b1;
        lat = i;
        v   = cur;
      end
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] m;
    int         lat;
    bit         ok;

    vecs[0] = '{"first_a5", 100, 1, 100, 8'hA5};
    vecs[1] = '{"frame_a6",  90, 72, 80, 8'hA6};
    vecs[2] = '{"frame_a7",  90, 72, 80, 8'hA7};
    vecs[3] = '{"frame_a8",  90, 72, 80, 8'hA8};
    vecs[4] = '{"frame_a9",  90, 72, 80, 8'hA9};
    vecs[5] = '{"frame_aa",  90, 72, 80, 8'hAA};

    // reset, then idle with tx_enable low
    rst    = 1'b0;
    tx_en  = 1'b0;
    tx_en2 = 1'b0;
    repeat (5) @(negedge clk);
    check8("reset_dout", dout, 8'h00);
    check8("reset_dout2", dout2, 8'h00);
    rst = 1'b1;
    wait_change(1'b0, 200, v, lat, ok);
    check_bit("idle_no_frame", ok, 1'b0);
    check8("idle_dout", dout, 8'h00);

    // first frames with gap checks
    tx_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_change(1'b0, vecs[k].budget, v, lat, ok);
      check_bit({vecs[k].name, "_seen"}, ok, 1'b1);
      check8(vecs[k].name, v, vecs[k].exp);
      if (ok) check_range({vecs[k].name, "_gap"}, lat, vecs[k].min_gap, vecs[k].max_gap);
    end

    // long run through the FF->00 wrap
    m = 8'hAB;
    while (m != 8'h03) begin
      exp_q.push_back(m);
      m = m + 8'h01;
    end
    while (exp_q.size() > 0) begin
      wait_change(1'b0, 90, v, lat, ok);
      check8("run_seq", v, exp_q.pop_front());
      if (!ok) begin
        check_bit("run_timeout", ok, 1'b1);
        exp_q.delete();
      end
    end

    // drop tx_enable mid-frame: frame completes, then dout holds
    repeat (40) @(negedge clk);
    tx_en = 1'b0;
    wait_change(1'b0, 80, v, lat, ok);
    check_bit("drop_frame_done", ok, 1'b1);
    check8("drop_last", v, 8'h03);
    wait_change(1'b0, 300, v, lat, ok);
    check_bit("drop_quiet", ok, 1'b0);
    check8("drop_hold", dout, 8'h03);

    // re-enable continues the sequence
    tx_en = 1'b1;
    wait_change(1'b0, 120, v, lat, ok);
    check8("resume_04", v, 8'h04);

    // reset mid-frame
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check8("midreset_dout", dout, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_change(1'b0, 120, v, lat, ok);
    check8("after_reset_a5", v, 8'hA5);

    // second instance: half period, seed 3C step 05
    tx_en2 = 1'b1;
    m = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      wait_change(1'b1, (k == 0) ? 60 : 50, v, lat, ok);
      check8("div2_seq", v, m);
      if (k > 0 && ok) check_range("div2_gap", lat, 36, 40);
      m = m + 8'h05;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
